// File: rtl/astro_rom_loader_pkg.sv
// Shared types and defaults for the ioctl -> dpram ROM loader.
package astro_loader_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WR_LO  = 2'd1,
        WR_HI  = 2'd2,
        FINISH = 2'd3
    } state_t;

    localparam int          ADDR_W_DEF   = 13;
    localparam logic [7:0]  IDX_BIOS_DEF = 8'd0;
    localparam logic [7:0]  IDX_CART_DEF = 8'd1;
    localparam int          ROM_BYTES    = 1 << ADDR_W_DEF;

endpackage

// File: rtl/astro_rom_loader_if.sv
// hps_io download bus as seen by the ROM loader; master = hps_io side, slave = loader.
interface astro_rom_loader_if;

    logic        ioctl_download;
    logic        ioctl_wr;
    logic [24:0] ioctl_addr;
    logic [15:0] ioctl_dout;
    logic [7:0]  ioctl_index;
    logic        ioctl_wait;

    modport master (
        output ioctl_download, ioctl_wr, ioctl_addr, ioctl_dout, ioctl_index,
        input  ioctl_wait
    );

    modport slave (
        input  ioctl_download, ioctl_wr, ioctl_addr, ioctl_dout, ioctl_index,
        output ioctl_wait
    );

endinterface

// File: rtl/astro_size_mask.sv
// Cart size -> mirror mask: (smallest 2^k >= size) - 1, k clamped to [8, ADDR_W]; size 0 -> all ones.
module astro_size_mask #(
    parameter int ADDR_W = 13
) (
    input  logic [15:0]       i_size,
    output logic [ADDR_W-1:0] o_mask
);

    // Scan from the largest window down so the smallest fitting power of two wins.
    always_comb begin
        o_mask = '1;
        if (i_size != 16'd0) begin
            for (int k = ADDR_W; k >= 8; k--) begin
                if ({16'd0, i_size} <= (32'd1 << k)) begin
                    o_mask = ADDR_W'((32'd1 << k) - 32'd1);
                end
            end
        end
    end

endmodule

// File: rtl/astro_rom_loader.sv
// Splits 16-bit hps_io download words into byte writes for the cart/BIOS dpram images.
// Optional macro ROM_CSUM_EN adds a 16-bit wrapping checksum of written cart bytes.
module astro_rom_loader
    import astro_loader_pkg::*;
#(
    parameter int         ADDR_W   = ADDR_W_DEF,
    parameter logic [7:0] IDX_BIOS = IDX_BIOS_DEF,
    parameter logic [7:0] IDX_CART = IDX_CART_DEF
) (
    input  logic                clk_sys,
    input  logic                reset,
    astro_rom_loader_if.slave   ioctl,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [7:0]          mem_data,
    output logic                cart_we,
    output logic                bios_we,
    input  logic [ADDR_W-1:0]   cpu_cart_addr,
    output logic [ADDR_W-1:0]   cart_rd_addr,
    output logic [15:0]         cart_size,
    output logic [ADDR_W-1:0]   cart_mask,
    output logic                overflow,
    output logic                load_done,
    output logic [15:0]         csum
);

    state_t            r_state, w_next;
    logic              r_dl_prev, r_fin_pend, r_oor, r_ovf;
    logic [15:0]       r_word, r_size, w_size_end;
    logic [ADDR_W-1:0] r_addr, r_mask, w_mask;
    logic [7:0]        r_idx, r_dl_idx;
    logic              w_dl_rise, w_dl_fall, w_busy;

    assign w_dl_rise  = ioctl.ioctl_download & ~r_dl_prev;
    assign w_dl_fall  = ~ioctl.ioctl_download & r_dl_prev;
    assign w_busy     = (r_state == WR_LO) || (r_state == WR_HI);
    assign w_size_end = 16'(r_addr) + 16'd2;

    astro_size_mask #(.ADDR_W(ADDR_W)) u_size_mask (
        .i_size (r_size),
        .o_mask (w_mask)
    );

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (w_dl_fall)
                    w_next = FINISH;
                else if (ioctl.ioctl_wr && ioctl.ioctl_download)
                    w_next = WR_LO;
            end
            WR_LO:   w_next = WR_HI;
            WR_HI:   w_next = (r_fin_pend || w_dl_fall) ? FINISH : IDLE;
            FINISH:  w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        mem_addr = '0;
        mem_data = 8'h00;
        if (r_state == WR_LO) begin
            mem_addr = r_addr;
            mem_data = r_word[7:0];
        end else if (r_state == WR_HI) begin
            mem_addr = r_addr + ADDR_W'(1);
            mem_data = r_word[15:8];
        end
    end

    assign cart_we          = w_busy && !r_oor && (r_idx == IDX_CART);
    assign bios_we          = w_busy && !r_oor && (r_idx == IDX_BIOS);
    assign ioctl.ioctl_wait = w_busy;
    assign load_done        = (r_state == FINISH);
    assign cart_size        = r_size;
    assign cart_mask        = r_mask;
    assign overflow         = r_ovf;
    assign cart_rd_addr     = cpu_cart_addr & r_mask;

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            r_state    <= IDLE;
            r_dl_prev  <= 1'b0;
            r_fin_pend <= 1'b0;
            r_word     <= '0;
            r_addr     <= '0;
            r_oor      <= 1'b0;
            r_idx      <= '0;
            r_dl_idx   <= '0;
            r_size     <= '0;
            r_mask     <= '1;
            r_ovf      <= 1'b0;
        end else begin
            r_state   <= w_next;
            r_dl_prev <= ioctl.ioctl_download;

            if (r_state == IDLE && w_next == WR_LO) begin
                r_word <= ioctl.ioctl_dout;
                r_addr <= ioctl.ioctl_addr[ADDR_W-1:0];
                r_oor  <= |ioctl.ioctl_addr[24:ADDR_W];
                r_idx  <= ioctl.ioctl_index;
            end

            if (w_dl_rise) begin
                r_dl_idx <= ioctl.ioctl_index;
                r_ovf    <= 1'b0;
                if (ioctl.ioctl_index == IDX_CART)
                    r_size <= '0;
            end

            if (r_state == WR_LO) begin
                if (r_oor)
                    r_ovf <= 1'b1;
                else if (r_idx == IDX_CART && w_size_end > r_size)
                    r_size <= w_size_end;
            end

            // A download that ends mid-word is remembered so the word completes first.
            if (r_state == WR_LO && w_dl_fall)
                r_fin_pend <= 1'b1;
            else if (r_state == WR_HI)
                r_fin_pend <= 1'b0;

            // Mask is updated on entry to FINISH so it is already valid during load_done.
            if (w_next == FINISH && r_state != FINISH && r_dl_idx == IDX_CART)
                r_mask <= w_mask;
        end
    end

`ifdef ROM_CSUM_EN
    logic [15:0] r_csum;

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset)
            r_csum <= '0;
        else if (w_dl_rise && ioctl.ioctl_index == IDX_CART)
            r_csum <= '0;
        else if (cart_we)
            r_csum <= r_csum + {8'h00, mem_data};
    end

    assign csum = r_csum;
`else
    assign csum = 16'h0000;
`endif

endmodule

// File: tb/tb_astro_rom_loader.sv
// Scoreboard bench for astro_rom_loader: stimulus pushes expected bytes/done results, a monitor pops and compares.
module tb_astro_rom_loader;
    import astro_loader_pkg::*;

    localparam int AW = 13;

    logic          clk_sys = 1'b0;
    logic          reset   = 1'b1;
    logic [AW-1:0] mem_addr, cpu_cart_addr, cart_rd_addr, cart_mask;
    logic [7:0]    mem_data;
    logic          cart_we, bios_we, overflow, load_done;
    logic [15:0]   cart_size, csum;

    always #5 clk_sys = ~clk_sys;

    astro_rom_loader_if ioctl_if ();

    astro_rom_loader dut (
        .clk_sys       (clk_sys),
        .reset         (reset),
        .ioctl         (ioctl_if),
        .mem_addr      (mem_addr),
        .mem_data      (mem_data),
        .cart_we       (cart_we),
        .bios_we       (bios_we),
        .cpu_cart_addr (cpu_cart_addr),
        .cart_rd_addr  (cart_rd_addr),
        .cart_size     (cart_size),
        .cart_mask     (cart_mask),
        .overflow      (overflow),
        .load_done     (load_done),
        .csum          (csum)
    );

    typedef struct packed {
        logic          is_cart;
        logic [AW-1:0] addr;
        logic [7:0]    data;
    } wr_t;

    typedef struct packed {
        logic [15:0]   size;
        logic [AW-1:0] mask;
        logic          ovf;
        logic [15:0]   sum;
    } done_t;

    wr_t   wr_q[$];
    done_t done_q[$];
    wr_t   mon_w;
    done_t mon_d;
    int    checks   = 0;
    int    failures = 0;

    // Reference model state: what the loader should report after each download.
    int    m_size, m_mask, m_csum, m_idx;
    bit    m_ovf;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    function automatic int model_mask(input int size);
        int p;
        if (size == 0) return 32'h1FFF;
        p = 256;
        while (p < size) p = p * 2;
        if (p > 8192) return 32'h1FFF;
        return p - 1;
    endfunction

    function automatic int exp_csum();
`ifdef ROM_CSUM_EN
        return m_csum;
`else
        return 0;
`endif
    endfunction

    always @(negedge clk_sys) begin
        if (!reset) begin
            if (cart_we || bios_we) begin
                if (wr_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_write cart_we=%0b bios_we=%0b addr=0x%0h data=0x%0h required=no write",
                             cart_we, bios_we, mem_addr, mem_data);
                end else begin
                    mon_w = wr_q.pop_front();
                    chk("wr_select", {30'd0, cart_we, bios_we}, {30'd0, mon_w.is_cart, ~mon_w.is_cart});
                    chk("wr_addr", 32'(mem_addr), 32'(mon_w.addr));
                    chk("wr_data", 32'(mem_data), 32'(mon_w.data));
                end
            end
            if (load_done) begin
                if (done_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_load_done actual=1 required=0");
                end else begin
                    mon_d = done_q.pop_front();
                    chk("done_cart_size", 32'(cart_size), 32'(mon_d.size));
                    chk("done_cart_mask", 32'(cart_mask), 32'(mon_d.mask));
                    chk("done_overflow", 32'(overflow), 32'(mon_d.ovf));
                    chk("done_csum", 32'(csum), 32'(mon_d.sum));
                end
            end
        end
    end

    task automatic start_dl(input logic [7:0] idx);
        ioctl_if.ioctl_index    = idx;
        ioctl_if.ioctl_download = 1'b1;
        m_idx = int'(idx);
        m_ovf = 1'b0;
        if (idx == 8'd1) begin
            m_size = 0;
            m_csum = 0;
        end
        @(negedge clk_sys);
    endtask

    task automatic push_done();
        ioctl_if.ioctl_download = 1'b0;
        if (m_idx == 1) m_mask = model_mask(m_size);
        done_q.push_back('{size: 16'(m_size), mask: AW'(m_mask), ovf: m_ovf, sum: 16'(exp_csum())});
    endtask

    task automatic wait_done();
        for (int i = 0; i < 20 && done_q.size() != 0; i++) @(negedge clk_sys);
        chk("load_done_timeout", 32'(done_q.size()), 32'd0);
        chk("writes_outstanding", 32'(wr_q.size()), 32'd0);
    endtask

    task automatic end_dl();
        push_done();
        wait_done();
    endtask

    // Called just after a negedge; returns at the negedge where the loader is idle again.
    task automatic send_word(input int addr, input logic [15:0] d, input bit drop);
        ioctl_if.ioctl_wr   = 1'b1;
        ioctl_if.ioctl_addr = 25'(addr);
        ioctl_if.ioctl_dout = d;
        if (addr >= 8192) begin
            m_ovf = 1'b1;
        end else if (m_idx == 1 || m_idx == 0) begin
            wr_q.push_back('{is_cart: (m_idx == 1), addr: AW'(addr),     data: d[7:0]});
            wr_q.push_back('{is_cart: (m_idx == 1), addr: AW'(addr + 1), data: d[15:8]});
            if (m_idx == 1) begin
                if (addr + 2 > m_size) m_size = addr + 2;
                m_csum = (m_csum + int'(d[7:0]) + int'(d[15:8])) % 65536;
            end
        end
        @(negedge clk_sys);
        ioctl_if.ioctl_wr = 1'b0;
        if (drop) push_done();
        chk("wait_cycle1", 32'(ioctl_if.ioctl_wait), 32'd1);
        @(negedge clk_sys);
        chk("wait_cycle2", 32'(ioctl_if.ioctl_wait), 32'd1);
        @(negedge clk_sys);
        chk("wait_released", 32'(ioctl_if.ioctl_wait), 32'd0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int nw, a;
        bit drop;
        logic [7:0] idx;
        logic [AW-1:0] ca;

        ioctl_if.ioctl_download = 1'b0;
        ioctl_if.ioctl_wr       = 1'b0;
        ioctl_if.ioctl_addr     = '0;
        ioctl_if.ioctl_dout     = '0;
        ioctl_if.ioctl_index    = '0;
        cpu_cart_addr           = '0;
        m_size = 0; m_mask = 32'h1FFF; m_csum = 0; m_idx = 0; m_ovf = 1'b0;

        repeat (3) @(negedge clk_sys);
        chk("rst_wait", 32'(ioctl_if.ioctl_wait), 32'd0);
        chk("rst_we", {30'd0, cart_we, bios_we}, 32'd0);
        chk("rst_cart_mask", 32'(cart_mask), 32'h1FFF);
        chk("rst_cart_size", 32'(cart_size), 32'd0);
        chk("rst_overflow", 32'(overflow), 32'd0);
        chk("rst_load_done", 32'(load_done), 32'd0);
        chk("rst_csum", 32'(csum), 32'd0);
        chk("rst_mem_addr", 32'(mem_addr), 32'd0);
        reset = 1'b0;
        @(negedge clk_sys);

        // BIOS word, low byte then high byte
        start_dl(8'd0);
        send_word(0, 16'hA55A, 1'b0);
        end_dl();

        // 2 KB cart, mirrored reads
        start_dl(8'd1);
        for (int w = 0; w < 1024; w++) send_word(w * 2, 16'($urandom), 1'b0);
        end_dl();
        chk("t2_cart_size", 32'(cart_size), 32'h0800);
        chk("t2_cart_mask", 32'(cart_mask), 32'h07FF);
        cpu_cart_addr = 13'h1234;
        #1;
        chk("t2_cart_rd_addr", 32'(cart_rd_addr), 32'h0234);

        // out-of-range word sets sticky overflow, size untouched
        start_dl(8'd1);
        for (int w = 0; w < 128; w++) send_word(w * 2, 16'($urandom), 1'b0);
        send_word(32'h2000, 16'hBEEF, 1'b0);
        chk("t3_overflow", 32'(overflow), 32'd1);
        chk("t3_cart_size", 32'(cart_size), 32'h0100);
        end_dl();
        start_dl(8'd0);
        chk("t3_overflow_cleared", 32'(overflow), 32'd0);
        end_dl();

        // unknown index: handshake only
        start_dl(8'd5);
        send_word(16'h0040, 16'h1357, 1'b0);
        chk("t4_cart_size", 32'(cart_size), 32'h0100);
        end_dl();

        // randomized downloads, some ending mid-word
        for (int it = 0; it < 8; it++) begin
            case ($urandom_range(0, 3))
                0:       idx = 8'd0;
                3:       idx = 8'd3;
                default: idx = 8'd1;
            endcase
            start_dl(idx);
            nw = int'($urandom_range(1, 24));
            drop = 1'b0;
            for (int w = 0; w < nw; w++) begin
                if ($urandom_range(0, 99) < 8) a = 32'h2000 + 2 * int'($urandom_range(0, 1000));
                else                           a = 2 * int'($urandom_range(0, 4095));
                drop = (w == nw - 1) && ($urandom_range(0, 1) == 1);
                send_word(a, 16'($urandom), drop);
            end
            if (drop) wait_done();
            else      end_dl();
            ca = AW'($urandom);
            cpu_cart_addr = ca;
            #1;
            chk("rand_cart_rd_addr", 32'(cart_rd_addr), 32'(ca) & 32'(m_mask));
            chk("rand_cart_size", 32'(cart_size), 32'(m_size));
        end

        // reset while the low byte is being written
        start_dl(8'd1);
        ioctl_if.ioctl_wr   = 1'b1;
        ioctl_if.ioctl_addr = 25'h10;
        ioctl_if.ioctl_dout = 16'h1234;
        wr_q.push_back('{is_cart: 1'b1, addr: AW'(16), data: 8'h34});
        @(negedge clk_sys);
        ioctl_if.ioctl_wr = 1'b0;
        #2;
        reset = 1'b1;
        ioctl_if.ioctl_download = 1'b0;
        #1;
        chk("t5_wait", 32'(ioctl_if.ioctl_wait), 32'd0);
        chk("t5_we", {30'd0, cart_we, bios_we}, 32'd0);
        chk("t5_cart_mask", 32'(cart_mask), 32'h1FFF);
        chk("t5_cart_size", 32'(cart_size), 32'd0);
        m_size = 0; m_mask = 32'h1FFF; m_csum = 0; m_ovf = 1'b0;
        @(negedge clk_sys);
        reset = 1'b0;
        repeat (4) @(negedge clk_sys);
        chk("t5_no_hi_write", 32'(wr_q.size()), 32'd0);

        // 512 bytes of 0xFF
        start_dl(8'd1);
        for (int w = 0; w < 256; w++) send_word(w * 2, 16'hFFFF, 1'b0);
        end_dl();
`ifdef ROM_CSUM_EN
        chk("t6_csum", 32'(csum), 32'hFE00);
`else
        chk("t6_csum", 32'(csum), 32'h0000);
`endif
        chk("t6_cart_mask", 32'(cart_mask), 32'h01FF);

        chk("final_writes_outstanding", 32'(wr_q.size()), 32'd0);
        chk("final_done_outstanding", 32'(done_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
